// File: rtl/pong_motion_ctrl.sv
// rtl/pong_motion_ctrl.sv - per-frame ball/paddle motion with combinational pixel colouring
module pong_motion_ctrl #(
  parameter int BALL_SIZE    = 8,
  parameter int PAD_H        = 72,
  parameter int PAD_V        = 4,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic        hit,
  output logic        miss,
  output logic [3:0]  score
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] X_CENTRE    = 10'd320;
  localparam logic [9:0] Y_CENTRE    = 10'd240;
  localparam logic [9:0] PAD_Y_RST   = 10'd204;
  localparam logic [9:0] PAD_X0      = 10'd600;
  localparam logic [9:0] PAD_X1      = 10'd603;
  localparam logic [9:0] WALL_X0     = 10'd32;
  localparam logic [9:0] WALL_X1     = 10'd35;
  localparam logic [9:0] LEFT_LIMIT  = 10'd36;
  localparam logic [9:0] PAD_STEP    = 10'(PAD_V);
  localparam logic [9:0] BALL_STEP   = 10'(BALL_V);
  localparam logic [9:0] PAD_Y_MAX   = 10'(480 - PAD_H);
  localparam logic [9:0] BALL_X_MISS = 10'(640 - BALL_SIZE);
  localparam logic [9:0] BALL_Y_BOT  = 10'(480 - BALL_SIZE - BALL_V);
  localparam logic [9:0] BALL_EXT    = 10'(BALL_SIZE - 1);
  localparam logic [9:0] PAD_EXT     = 10'(PAD_H - 1);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic [9:0]       ball_x, ball_y, pad_y;
  logic             dx, dy;
  logic             cond_d;

  logic       frame_cond, tick;
  logic [9:0] pad_next, ball_right, ball_bot, pad_bot;
  logic       paddle_hit, dx_next, dy_next;

  assign frame_cond = (pixel_y == 10'd481) && (pixel_x == 10'd0);
  assign tick       = frame_cond && !cond_d;

  assign ball_right = ball_x + BALL_EXT;
  assign ball_bot   = ball_y + BALL_EXT;
  assign pad_bot    = pad_y + PAD_EXT;

  assign paddle_hit = dx && (ball_right >= PAD_X0) && (ball_right <= PAD_X1)
                      && (ball_bot >= pad_y) && (ball_y <= pad_bot);

  always_comb begin
    dx_next = dx;
    if (paddle_hit)
      dx_next = 1'b0;
    else if (ball_x <= LEFT_LIMIT)
      dx_next = 1'b1;
    dy_next = dy;
    if (ball_y <= BALL_STEP)
      dy_next = 1'b1;
    else if (ball_y >= BALL_Y_BOT)
      dy_next = 1'b0;
  end

  // Conflicting buttons cancel; clamps keep the paddle fully on screen.
  always_comb begin
    pad_next = pad_y;
    if (btn_up && !btn_down)
      pad_next = (pad_y < PAD_STEP) ? 10'd0 : pad_y - PAD_STEP;
    else if (btn_down && !btn_up)
      pad_next = (pad_y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : pad_y + PAD_STEP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= '0;
      ball_x    <= X_CENTRE;
      ball_y    <= Y_CENTRE;
      dx        <= 1'b1;
      dy        <= 1'b1;
      pad_y     <= PAD_Y_RST;
      score     <= 4'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      cond_d    <= 1'b0;
    end else begin
      cond_d <= frame_cond;
      hit    <= 1'b0;
      miss   <= 1'b0;
      if (tick) begin
        pad_y <= pad_next;
        if (state == SERVE) begin
          ball_x <= X_CENTRE;
          ball_y <= Y_CENTRE;
          dx     <= 1'b1;
          dy     <= 1'b1;
          if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            state     <= PLAY;
            serve_cnt <= '0;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end else if (ball_x >= BALL_X_MISS) begin
          miss      <= 1'b1;
          score     <= 4'd0;
          ball_x    <= X_CENTRE;
          ball_y    <= Y_CENTRE;
          dx        <= 1'b1;
          dy        <= 1'b1;
          serve_cnt <= '0;
          state     <= SERVE;
        end else begin
          if (paddle_hit) begin
            hit <= 1'b1;
            if (score != 4'd15)
              score <= score + 4'd1;
          end
          dx     <= dx_next;
          dy     <= dy_next;
          ball_x <= dx_next ? ball_x + BALL_STEP : ball_x - BALL_STEP;
          ball_y <= dy_next ? ball_y + BALL_STEP : ball_y - BALL_STEP;
        end
      end
    end
  end

  // Extended to 11 bits so the far-edge comparisons cannot wrap.
  logic ball_on, pad_on, wall_on;

  assign ball_on = ({1'b0, pixel_x} >= {1'b0, ball_x})
                && ({1'b0, pixel_x} <  {1'b0, ball_x} + 11'(BALL_SIZE))
                && ({1'b0, pixel_y} >= {1'b0, ball_y})
                && ({1'b0, pixel_y} <  {1'b0, ball_y} + 11'(BALL_SIZE));
  assign pad_on  = (pixel_x >= PAD_X0) && (pixel_x <= PAD_X1)
                && ({1'b0, pixel_y} >= {1'b0, pad_y})
                && ({1'b0, pixel_y} <  {1'b0, pad_y} + 11'(PAD_H));
  assign wall_on = (pixel_x >= WALL_X0) && (pixel_x <= WALL_X1);

  always_comb begin
    rgb = 12'h000;
    if (video_on) begin
      if (ball_on)
        rgb = 12'hF00;
      else if (pad_on)
        rgb = 12'h0F0;
      else if (wall_on)
        rgb = 12'h00F;
    end
  end

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// tb/tb_pong_motion_ctrl.sv - directed scenarios plus random play against a frame-level game model
module tb_pong_motion_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [11:0] rgb;
  logic        hit, miss;
  logic [3:0]  score;

  pong_motion_ctrl dut (
    .clock(clock), .reset(reset), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .btn_up(btn_up), .btn_down(btn_down),
    .rgb(rgb), .hit(hit), .miss(miss), .score(score)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: positions, velocity signs, paddle, serve frame count.
  int bx, by, sdx, sdy, pdy, playing, scnt, sc, ehit, emiss;
  int prev_cond;
  int saw_hit, saw_miss;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bx = 320; by = 240; sdx = 1; sdy = 1; pdy = 204;
    playing = 0; scnt = 0; sc = 0; ehit = 0; emiss = 0; prev_cond = 0;
  endtask

  task automatic model_tick(input int u, input int d);
    int np;
    ehit = 0; emiss = 0;
    np = pdy;
    if (u && !d) np = (pdy - 4 < 0) ? 0 : pdy - 4;
    if (d && !u) np = (pdy + 4 > 408) ? 408 : pdy + 4;
    if (!playing) begin
      scnt++;
      if (scnt == 60) begin playing = 1; scnt = 0; end
    end else if (bx >= 632) begin
      emiss = 1; sc = 0; bx = 320; by = 240; sdx = 1; sdy = 1; playing = 0; scnt = 0;
    end else begin
      if (sdx > 0 && bx + 7 >= 600 && bx + 7 <= 603 && by + 7 >= pdy && by <= pdy + 71) begin
        sdx = -1; ehit = 1; sc = (sc == 15) ? 15 : sc + 1;
      end
      if (bx <= 36) sdx = 1;
      if (by <= 2) sdy = 1;
      if (by >= 470) sdy = -1;
      bx += 2 * sdx;
      by += 2 * sdy;
    end
    pdy = np;
  endtask

  function automatic int model_rgb(input int v, input int x, input int y);
    if (!v) return 12'h000;
    if (x >= bx && x < bx + 8 && y >= by && y < by + 8) return 12'hF00;
    if (x >= 600 && x <= 603 && y >= pdy && y < pdy + 72) return 12'h0F0;
    if (x >= 32 && x <= 35) return 12'h00F;
    return 12'h000;
  endfunction

  // One clock: drive, let the edge happen, advance the model, compare everything.
  task automatic cycle(input int v, input int x, input int y, input int u, input int d);
    int tk, c;
    video_on = v[0]; pixel_x = x[9:0]; pixel_y = y[9:0]; btn_up = u[0]; btn_down = d[0];
    c  = (x == 0 && y == 481) ? 1 : 0;
    tk = c && !prev_cond;
    prev_cond = c;
    @(posedge clock);
    #1;
    if (tk) model_tick(u, d);
    else begin ehit = 0; emiss = 0; end
    chk("hit", hit, ehit);
    chk("miss", miss, emiss);
    chk("score", score, sc);
    chk("rgb", rgb, model_rgb(v, x, y));
    if (hit) saw_hit = 1;
    if (miss) saw_miss = 1;
  endtask

  task automatic do_reset();
    pixel_x = 10'd0; pixel_y = 10'd0; btn_up = 1'b0; btn_down = 1'b0; video_on = 1'b1;
    reset = 1'b1;
    model_reset();
    #2;
    chk("reset_hit", hit, 0);
    chk("reset_miss", miss, 0);
    chk("reset_score", score, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input int exp);
    cycle(1, x, y, 0, 0);
    chk(name, rgb, exp);
  endtask

  task automatic frame(input int u, input int d, input int hold);
    saw_hit = 0; saw_miss = 0;
    for (int i = 0; i < hold; i++) cycle(1, 0, 481, u, d);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic rand_pixel(output int x, output int y);
    case ($urandom_range(0, 3))
      0: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
      1: begin x = bx - 1 + $urandom_range(0, 9); y = by - 1 + $urandom_range(0, 9); end
      2: begin x = $urandom_range(598, 605); y = pdy - 1 + $urandom_range(0, 73); end
      default: begin x = $urandom_range(30, 37); y = $urandom_range(0, 479); end
    endcase
    if (y < 0) y = 0;
  endtask

  initial begin
    int x, y, u, d;
    model_reset();
    #12;
    do_reset();

    probe("rst_ball", 322, 242, 12'hF00);
    probe("rst_pad", 601, 210, 12'h0F0);
    probe("rst_wall", 33, 10, 12'h00F);
    cycle(0, 322, 242, 0, 0);
    chk("rst_blank", rgb, 12'h000);

    // Serve with btn_up held: paddle pins at 0, ball held at centre.
    for (int k = 1; k <= 60; k++) frame(1, 0, 5);
    probe("serve_ball", 320, 240, 12'hF00);
    probe("serve_ball_edge", 319, 240, 12'h000);
    probe("pad_top", 601, 0, 12'h0F0);
    probe("pad_below", 601, 72, 12'h000);
    frame(0, 0, 5);
    probe("play1_ball", 322, 242, 12'hF00);
    probe("play1_edge", 321, 242, 12'h000);
    for (int k = 2; k <= 157; k++) begin
      frame(0, 0, 5);
      if (k == 116) begin
        probe("bounce_bot", 552, 468, 12'hF00);
        probe("bounce_bot_edge", 552, 467, 12'h000);
      end
      if (k == 156) chk("no_miss_yet", saw_miss, 0);
      if (k == 157) chk("miss_seen", saw_miss, 1);
    end
    chk("miss_score", score, 0);
    probe("miss_ball", 320, 240, 12'hF00);

    // Paddle parked at 364 so the ball returns off it.
    do_reset();
    for (int k = 1; k <= 40; k++) frame(0, 1, 5);
    for (int k = 41; k <= 45; k++) frame(1, 1, 5);
    probe("both_pad", 601, 364, 12'h0F0);
    probe("both_pad_edge", 601, 363, 12'h000);
    for (int k = 46; k <= 60; k++) frame(0, 0, 5);
    for (int k = 1; k <= 417; k++) begin
      frame(0, 0, 2);
      if (k == 137) chk("no_hit_yet", saw_hit, 0);
      if (k == 138) begin
        chk("hit_seen", saw_hit, 1);
        chk("hit_score", score, 1);
        probe("hit_ball", 592, 424, 12'hF00);
        probe("hit_edge", 591, 424, 12'h000);
      end
      if (k == 350) begin
        probe("bounce_top", 168, 4, 12'hF00);
        probe("bounce_top_edge", 168, 3, 12'h000);
      end
      if (k == 417) begin
        probe("bounce_wall", 38, 138, 12'hF00);
        probe("bounce_wall_edge", 37, 138, 12'h000);
      end
    end

    // Random play with a loosely tracking paddle and occasional resets.
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(0, 3) != 0) begin
        u = (by + 4 < pdy + 28) ? 1 : 0;
        d = (by + 4 > pdy + 44) ? 1 : 0;
      end else begin
        u = $urandom_range(0, 1);
        d = $urandom_range(0, 1);
      end
      for (int i = $urandom_range(1, 5); i > 0; i--) cycle(1, 0, 481, u, d);
      for (int i = $urandom_range(3, 8); i > 0; i--) begin
        rand_pixel(x, y);
        cycle($urandom_range(0, 7) != 0, x, y, $urandom_range(0, 1), $urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
